// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce bank: per-channel FSM encoding and counter sizing.
package debounce_pkg;

    typedef enum logic [0:0] {
        ST_STABLE = 1'b0,
        ST_SETTLE = 1'b1
    } ch_state_e;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// Single debounce channel: two-flop synchroniser, settle FSM, hold counter and
// registered level/press/release/long-press outputs.
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int unsigned DB_CYC     = 500000,
    parameter int unsigned LONG_CYC   = 50000000,
    parameter logic        ACTIVE_LVL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic long_press
);

    localparam int unsigned SET_W  = cnt_width(DB_CYC);
    localparam int unsigned HOLD_W = cnt_width(LONG_CYC + 1);
    localparam logic [SET_W-1:0]  SET_LOAD = SET_W'(DB_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYC);
    localparam logic              IDLE_LVL = ~ACTIVE_LVL;

    logic              sync1_q;
    logic              sync2_q;
    ch_state_e         state_q;
    ch_state_e         state_d;
    logic [SET_W-1:0]  set_cnt_q;
    logic [SET_W-1:0]  set_cnt_d;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic              out_q;
    logic              out_d;
    logic              rise_q;
    logic              rise_d;
    logic              fall_q;
    logic              fall_d;
    logic              long_q;
    logic              long_d;

    // Synchroniser resets to the idle level so a held press is re-debounced after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= IDLE_LVL;
            sync2_q <= IDLE_LVL;
        end else begin
            sync1_q <= in_raw;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_STABLE;
            set_cnt_q <= '0;
            hold_q    <= '0;
            out_q     <= IDLE_LVL;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            set_cnt_q <= set_cnt_d;
            hold_q    <= hold_d;
            out_q     <= out_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            long_q    <= long_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        set_cnt_d = set_cnt_q;
        out_d     = out_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        hold_d    = hold_q;
        long_d    = 1'b0;

        unique case (state_q)
            ST_STABLE: begin
                if (sync2_q != out_q) begin
                    state_d   = ST_SETTLE;
                    set_cnt_d = SET_LOAD;
                end
            end
            ST_SETTLE: begin
                // Any return to the committed level mid-window is treated as bounce.
                if (sync2_q == out_q) begin
                    state_d   = ST_STABLE;
                    set_cnt_d = '0;
                end else if (set_cnt_q == '0) begin
                    state_d = ST_STABLE;
                    out_d   = sync2_q;
                    rise_d  = (sync2_q == ACTIVE_LVL);
                    fall_d  = (sync2_q != ACTIVE_LVL);
                end else begin
                    set_cnt_d = set_cnt_q - SET_W'(1);
                end
            end
            default: begin
                state_d   = ST_STABLE;
                set_cnt_d = '0;
            end
        endcase

        // Hold counter restarts on every commit and idles at zero while released.
        if (rise_d || fall_d || (out_q != ACTIVE_LVL)) begin
            hold_d = '0;
        end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + HOLD_W'(1);
            long_d = (LONG_CYC != 0) && (hold_d == HOLD_MAX);
        end
    end

    assign level      = out_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign long_press = long_q;

endmodule

// File: rtl/debounce_bank.sv
// Bank of N_CH independent debounce channels between board pins and UI control logic.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned DB_CYC     = 500000,
    parameter int unsigned LONG_CYC   = 50000000,
    parameter logic        ACTIVE_LVL = 1'b0
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [N_CH-1:0] IN,
    output logic [N_CH-1:0] OUT,
    output logic [N_CH-1:0] RISE,
    output logic [N_CH-1:0] FALL,
    output logic [N_CH-1:0] LONG
);

    for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
        debounce_ch #(
            .DB_CYC     (DB_CYC),
            .LONG_CYC   (LONG_CYC),
            .ACTIVE_LVL (ACTIVE_LVL)
        ) u_ch (
            .clk        (CLK),
            .rst_n      (RST_N),
            .in_raw     (IN[g]),
            .level      (OUT[g]),
            .rise       (RISE[g]),
            .fall       (FALL[g]),
            .long_press (LONG[g])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank: strobe scoreboard plus per-scenario level checks.
module tb_debounce_bank;

    localparam int unsigned N_CH       = 4;
    localparam int unsigned DB_CYC     = 8;
    localparam int unsigned LONG_CYC   = 32;
    localparam logic        ACTIVE_LVL = 1'b0;
    localparam int unsigned LAT        = DB_CYC + 2;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic [N_CH-1:0]  in_v  = '0;
    logic [N_CH-1:0]  out;
    logic [N_CH-1:0]  rise;
    logic [N_CH-1:0]  fall;
    logic [N_CH-1:0]  lng;

    int unsigned cyc = 0;
    int          tests_run = 0;
    int          tests_failed = 0;
    bit          mon_en = 1'b0;

    typedef struct {
        int unsigned     cyc;
        logic [N_CH-1:0] rise;
        logic [N_CH-1:0] fall;
        logic [N_CH-1:0] lng;
    } exp_t;

    exp_t sb[$];

    debounce_bank #(
        .N_CH       (N_CH),
        .DB_CYC     (DB_CYC),
        .LONG_CYC   (LONG_CYC),
        .ACTIVE_LVL (ACTIVE_LVL)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .IN    (in_v),
        .OUT   (out),
        .RISE  (rise),
        .FALL  (fall),
        .LONG  (lng)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic void push_exp(input int unsigned c, input logic [N_CH-1:0] r,
                                     input logic [N_CH-1:0] f, input logic [N_CH-1:0] l);
        exp_t e;
        e.cyc  = c;
        e.rise = r;
        e.fall = f;
        e.lng  = l;
        sb.push_back(e);
    endfunction

    task automatic run_to(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    endtask

    // Scoreboard: every strobe cycle must match the queued expectation for that cycle.
    logic [N_CH-1:0] er, ef, el;
    bit              hit;
    always @(negedge clk) begin
        if (mon_en) begin
            while (sb.size() != 0 && sb[0].cyc < cyc) begin
                tests_run++;
                tests_failed++;
                $display("FAIL missed_strobe expected at cycle %0d rise=%h fall=%h long=%h, now cycle %0d",
                         sb[0].cyc, sb[0].rise, sb[0].fall, sb[0].lng, cyc);
                sb.delete(0);
            end
            er  = '0;
            ef  = '0;
            el  = '0;
            hit = 1'b0;
            if (sb.size() != 0 && sb[0].cyc == cyc) begin
                er  = sb[0].rise;
                ef  = sb[0].fall;
                el  = sb[0].lng;
                hit = 1'b1;
                sb.delete(0);
            end
            if (hit || (rise | fall | lng) != '0) begin
                tests_run++;
                if ({rise, fall, lng} !== {er, ef, el}) begin
                    tests_failed++;
                    $display("FAIL strobes cycle %0d got rise=%h fall=%h long=%h exp rise=%h fall=%h long=%h",
                             cyc, rise, fall, lng, er, ef, el);
                end
            end
        end
    end

    task automatic test_reset();
        int unsigned e0;
        in_v = 4'h0;
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (out !== 4'hF || {rise, fall, lng} !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_async got out=%h strobes=%h exp out=F strobes=000", out, {rise, fall, lng});
        end
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        rst_n  = 1'b1;
        e0 = cyc + 1;
        push_exp(e0 + LAT, 4'hF, 4'h0, 4'h0);
        push_exp(e0 + LAT + LONG_CYC, 4'h0, 4'h0, 4'hF);
        run_to(e0 + LAT - 1);
        tests_run++;
        if (out !== 4'hF) begin
            tests_failed++;
            $display("FAIL reset_pre_commit got out=%h exp F", out);
        end
        run_to(e0 + LAT);
        tests_run++;
        if (out !== 4'h0) begin
            tests_failed++;
            $display("FAIL reset_commit got out=%h exp 0", out);
        end
        run_to(e0 + LAT + LONG_CYC + 2);
        in_v = 4'hF;
        e0 = cyc + 1;
        push_exp(e0 + LAT, 4'h0, 4'hF, 4'h0);
        drain();
        tests_run++;
        if (out !== 4'hF) begin
            tests_failed++;
            $display("FAIL reset_release got out=%h exp F", out);
        end
    endtask

    task automatic test_clean_press();
        int unsigned e0;
        in_v[0] = 1'b0;
        e0 = cyc + 1;
        push_exp(e0 + LAT, 4'h1, 4'h0, 4'h0);
        run_to(e0 + LAT - 1);
        tests_run++;
        if (out !== 4'hF) begin
            tests_failed++;
            $display("FAIL clean_pre_commit got out=%h exp F", out);
        end
        run_to(e0 + LAT);
        tests_run++;
        if (out !== 4'hE) begin
            tests_failed++;
            $display("FAIL clean_commit got out=%h exp E", out);
        end
        run_to(e0 + LAT + 2);
        in_v[0] = 1'b1;
        e0 = cyc + 1;
        push_exp(e0 + LAT, 4'h0, 4'h1, 4'h0);
        drain();
        tests_run++;
        if (out !== 4'hF) begin
            tests_failed++;
            $display("FAIL clean_release got out=%h exp F", out);
        end
    endtask

    task automatic test_bounce();
        int unsigned e0;
        in_v[1] = 1'b0;
        repeat (DB_CYC) @(negedge clk);
        in_v[1] = 1'b1;
        repeat (2 * LAT) @(negedge clk);
        tests_run++;
        if (out !== 4'hF) begin
            tests_failed++;
            $display("FAIL bounce_reject got out=%h exp F", out);
        end
        in_v[1] = 1'b0;
        e0 = cyc + 1;
        push_exp(e0 + LAT, 4'h2, 4'h0, 4'h0);
        repeat (DB_CYC + 1) @(negedge clk);
        in_v[1] = 1'b1;
        push_exp(cyc + 1 + LAT, 4'h0, 4'h2, 4'h0);
        drain();
        tests_run++;
        if (out !== 4'hF) begin
            tests_failed++;
            $display("FAIL bounce_min_pulse got out=%h exp F", out);
        end
    endtask

    task automatic test_chatter();
        logic        cur;
        int unsigned last;
        cur  = 1'b1;
        last = 0;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) begin
                cur     = ~cur;
                in_v[2] = cur;
                last    = cyc + 1;
            end
            @(negedge clk);
        end
        if (in_v[2] !== 1'b0) begin
            in_v[2] = 1'b0;
            last    = cyc + 1;
        end
        push_exp(last + LAT, 4'h4, 4'h0, 4'h0);
        run_to(last + LAT);
        tests_run++;
        if (out !== 4'hB) begin
            tests_failed++;
            $display("FAIL chatter_commit got out=%h exp B", out);
        end
        run_to(last + LAT + 2);
        in_v[2] = 1'b1;
        push_exp(cyc + 1 + LAT, 4'h0, 4'h4, 4'h0);
        drain();
    endtask

    task automatic test_long_press();
        int unsigned r;
        in_v[3] = 1'b0;
        r = cyc + 1 + LAT;
        push_exp(r, 4'h8, 4'h0, 4'h0);
        push_exp(r + LONG_CYC, 4'h0, 4'h0, 4'h8);
        run_to(r + LONG_CYC + 40);
        tests_run++;
        if (out !== 4'h7) begin
            tests_failed++;
            $display("FAIL long_held got out=%h exp 7", out);
        end
        in_v[3] = 1'b1;
        push_exp(cyc + 1 + LAT, 4'h0, 4'h8, 4'h0);
        drain();
        in_v[3] = 1'b0;
        push_exp(cyc + 1 + LAT, 4'h8, 4'h0, 4'h0);
        repeat (20) @(negedge clk);
        in_v[3] = 1'b1;
        push_exp(cyc + 1 + LAT, 4'h0, 4'h8, 4'h0);
        drain();
        repeat (LONG_CYC) @(negedge clk);
        tests_run++;
        if (out !== 4'hF) begin
            tests_failed++;
            $display("FAIL long_short_press got out=%h exp F", out);
        end
    endtask

    task automatic test_reset_mid();
        int unsigned e0;
        in_v = 4'h0;
        e0 = cyc + 1;
        run_to(e0 + 5);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out !== 4'hF || {rise, fall, lng} !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_mid_async got out=%h strobes=%h exp out=F strobes=000", out, {rise, fall, lng});
        end
        @(negedge clk);
        rst_n = 1'b1;
        e0 = cyc + 1;
        push_exp(e0 + LAT, 4'hF, 4'h0, 4'h0);
        push_exp(e0 + LAT + LONG_CYC, 4'h0, 4'h0, 4'hF);
        run_to(e0 + LAT);
        tests_run++;
        if (out !== 4'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_commit got out=%h exp 0", out);
        end
        run_to(e0 + LAT + LONG_CYC + 2);
        in_v = 4'hF;
        push_exp(cyc + 1 + LAT, 4'h0, 4'hF, 4'h0);
        drain();
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_chatter();
        test_long_press();
        test_reset_mid();
        repeat (4) @(negedge clk);
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_empty got %0d pending exp 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
